// File: rtl/register_readout_serializer_if.sv
// Bus between a register readout client and the serializer: parallel word
// and start request in, serial data/strobe and frame status out.
interface register_readout_serializer_if #(
  parameter int WIDTH = 16
);
  logic [WIDTH-1:0] value_in;
  logic             start;
  logic             busy;
  logic             frame;
  logic             serial_out;
  logic             serial_strobe;
  logic             done;

  // Client side: supplies the word and the request, observes the serial stream.
  modport master (
    output value_in,
    output start,
    input  busy,
    input  frame,
    input  serial_out,
    input  serial_strobe,
    input  done
  );

  // Serializer side.
  modport slave (
    input  value_in,
    input  start,
    output busy,
    output frame,
    output serial_out,
    output serial_strobe,
    output done
  );
endinterface

// File: rtl/register_readout_serializer.sv
// Snapshots a parallel register word on request and shifts it out on a single
// data wire with a strobe in the last cycle of every bit period. The snapshot
// lives in a shadow register so register writes during a frame are invisible.
//
// state | meaning
// IDLE  | waiting for start; all outputs low
// SHIFT | driving shadow bits, one bit per DIVIDE cycles
// DONE  | one-cycle done pulse, busy still high, then back to IDLE
module register_readout_serializer #(
  parameter int WIDTH     = 16,
  parameter int DIVIDE    = 1,
  parameter bit MSB_FIRST = 1'b1
) (
  input logic                          clock,
  input logic                          reset,
  register_readout_serializer_if.slave bus
);

  localparam int IDX_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam int DIV_W = (DIVIDE > 1) ? $clog2(DIVIDE) : 1;
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(WIDTH - 1);
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(DIVIDE - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  state_t           state,   state_nxt;
  logic [WIDTH-1:0] shadow,  shadow_nxt;
  logic [IDX_W-1:0] bit_idx, bit_idx_nxt;
  logic [DIV_W-1:0] div_cnt, div_cnt_nxt;

  logic             bit_end;
  logic [IDX_W-1:0] bit_sel;

  // Last cycle of the current bit period; with DIVIDE=1 this is every cycle.
  assign bit_end = (div_cnt == DIV_LAST);
  // Map the frame position onto the shadow bit according to shift order.
  assign bit_sel = MSB_FIRST ? (IDX_LAST - bit_idx) : bit_idx;

  // State, snapshot and counters; reset aborts any frame in flight.
  always_ff @(posedge clock) begin
    if (reset) begin
      state   <= IDLE;
      shadow  <= '0;
      bit_idx <= '0;
      div_cnt <= '0;
    end else begin
      state   <= state_nxt;
      shadow  <= shadow_nxt;
      bit_idx <= bit_idx_nxt;
      div_cnt <= div_cnt_nxt;
    end
  end

  // Next-state logic: capture on start in IDLE, advance bit on each strobe.
  always_comb begin
    state_nxt   = state;
    shadow_nxt  = shadow;
    bit_idx_nxt = bit_idx;
    div_cnt_nxt = div_cnt;
    case (state)
      IDLE: begin
        if (bus.start) begin
          shadow_nxt  = bus.value_in;
          bit_idx_nxt = '0;
          div_cnt_nxt = '0;
          state_nxt   = SHIFT;
        end
      end
      SHIFT: begin
        if (bit_end) begin
          div_cnt_nxt = '0;
          // Hold bit_idx at its terminal value rather than wrapping.
          if (bit_idx == IDX_LAST) begin
            state_nxt = DONE;
          end else begin
            bit_idx_nxt = bit_idx + IDX_W'(1);
          end
        end else begin
          div_cnt_nxt = div_cnt + DIV_W'(1);
        end
      end
      DONE: begin
        state_nxt = IDLE;
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

  // Outputs decoded purely from registered state; no input-to-output path.
  always_comb begin
    bus.busy          = 1'b0;
    bus.frame         = 1'b0;
    bus.serial_out    = 1'b0;
    bus.serial_strobe = 1'b0;
    bus.done          = 1'b0;
    case (state)
      SHIFT: begin
        bus.busy          = 1'b1;
        bus.frame         = 1'b1;
        bus.serial_out    = shadow[bit_sel];
        bus.serial_strobe = bit_end;
      end
      DONE: begin
        bus.busy = 1'b1;
        bus.done = 1'b1;
      end
      default: begin
        bus.busy = 1'b0;
      end
    endcase
  end

endmodule

// File: tb/tb_register_readout_serializer.sv
// Bench for register_readout_serializer: two instances (DIVIDE=1 MSB first,
// DIVIDE=4 LSB first) checked every cycle against a frame-timeline model,
// plus table-driven frame vectors and hand-written corner sequences.
module tb_register_readout_serializer;

  logic clk = 1'b0;
  logic rst = 1'b1;

  int n_checks = 0;
  int n_pass   = 0;

  register_readout_serializer_if #(.WIDTH(16)) if_a ();
  register_readout_serializer_if #(.WIDTH(16)) if_b ();

  register_readout_serializer #(.WIDTH(16), .DIVIDE(1), .MSB_FIRST(1'b1)) dut_a (
    .clock (clk),
    .reset (rst),
    .bus   (if_a)
  );

  register_readout_serializer #(.WIDTH(16), .DIVIDE(4), .MSB_FIRST(1'b0)) dut_b (
    .clock (clk),
    .reset (rst),
    .bus   (if_b)
  );

  always #5 clk = ~clk;

  // Model: t = cycles since the capturing edge (0 = idle). A frame occupies
  // t = 1 .. 16*D for the bits and t = 16*D+1 for the done cycle.
  int          mt[2];
  logic [15:0] mv[2];

  function automatic int div_of(int i);
    return (i == 0) ? 1 : 4;
  endfunction

  function automatic logic start_of(int i);
    return (i == 0) ? if_a.start : if_b.start;
  endfunction

  function automatic logic [15:0] val_of(int i);
    return (i == 0) ? if_a.value_in : if_b.value_in;
  endfunction

  // {busy, frame, serial_out, serial_strobe, done}
  function automatic logic [4:0] outs(int i);
    if (i == 0)
      return {if_a.busy, if_a.frame, if_a.serial_out, if_a.serial_strobe, if_a.done};
    return {if_b.busy, if_b.frame, if_b.serial_out, if_b.serial_strobe, if_b.done};
  endfunction

  function automatic logic [4:0] model_out(int t, logic [15:0] v, int d, bit msb);
    int   p;
    logic b;
    logic s;
    if (t == 0) return 5'b00000;
    if (t <= 16 * d) begin
      p = (t - 1) / d;
      b = msb ? v[15 - p] : v[p];
      s = (((t - 1) % d) == (d - 1));
      return {1'b1, 1'b1, b, s, 1'b0};
    end
    return 5'b10001;
  endfunction

  initial begin
    mt[0] = 0; mt[1] = 0;
    mv[0] = '0; mv[1] = '0;
  end

  always @(posedge clk) begin
    for (int i = 0; i < 2; i++) begin
      if (rst) begin
        mt[i] <= 0;
      end else if (mt[i] == 0) begin
        if (start_of(i)) begin
          mt[i] <= 1;
          mv[i] <= val_of(i);
        end
      end else if (mt[i] == 16 * div_of(i) + 1) begin
        mt[i] <= 0;
      end else begin
        mt[i] <= mt[i] + 1;
      end
    end
  end

  task automatic check_cycle();
    logic [4:0] got;
    logic [4:0] expv;
    for (int i = 0; i < 2; i++) begin
      got  = outs(i);
      expv = model_out(mt[i], mv[i], div_of(i), (i == 0));
      n_checks++;
      if (got === expv) n_pass++;
      else $display("FAIL cycle_%s t=%0d got=%b exp=%b", (i == 0) ? "a" : "b", mt[i], got, expv);
    end
  endtask

  task automatic chk(input string name, input int got, input int expv);
    n_checks++;
    if (got == expv) n_pass++;
    else $display("FAIL %s got=%0d (0x%0h) exp=%0d (0x%0h)", name, got, got, expv, expv);
  endtask

  // Advance to the next falling edge and compare both instances to the model.
  task automatic step();
    @(negedge clk);
    check_cycle();
  endtask

  task automatic drive(input int sel, input logic s, input logic [15:0] v);
    if (sel == 0) begin
      if_a.start    = s;
      if_a.value_in = v;
    end else begin
      if_b.start    = s;
      if_b.value_in = v;
    end
  endtask

  task automatic drive_start(input int sel, input logic s);
    if (sel == 0) if_a.start = s;
    else          if_b.start = s;
  endtask

  // Launch one frame and collect it. chg replaces value_in right after the
  // capture edge; poke (>=2) pulses start once mid-frame.
  task automatic run_frame(input int sel, input logic [15:0] val, input logic [15:0] chg,
                           input int poke, output logic [15:0] stream, output int busy_n,
                           output int strobe_n, output int frame_n, output int done_at,
                           output bit timed_out);
    logic [4:0] o;
    stream = '0; busy_n = 0; strobe_n = 0; frame_n = 0; done_at = -1; timed_out = 1'b1;
    drive(sel, 1'b1, val);
    for (int c = 1; c <= 200; c++) begin
      step();
      if (c == 1) drive(sel, 1'b0, chg);
      if (poke > 1 && c == poke) drive_start(sel, 1'b1);
      if (poke > 1 && c == poke + 1) drive_start(sel, 1'b0);
      o = outs(sel);
      if (o[4]) busy_n++;
      if (o[3]) frame_n++;
      if (o[1]) begin
        strobe_n++;
        stream = {stream[14:0], o[2]};
      end
      if (o[0]) done_at = c;
      if (!o[4]) begin
        timed_out = 1'b0;
        break;
      end
    end
  endtask

  typedef struct {
    int          sel;
    logic [15:0] val;
    logic [15:0] chg;
    int          poke;
    logic [15:0] exp_stream;
    int          exp_busy;
  } vec_t;

  vec_t vecs[8];

  initial begin
    logic [15:0] stream;
    int busy_n, strobe_n, frame_n, done_at;
    bit tmo;
    logic [4:0] o;
    int rises[$];
    int dones[$];
    logic prev_frame;
    int done_seen;

    // stream is assembled first-sent-bit-first into the MSB
    vecs[0] = '{0, 16'h001F, 16'h007F, 5,  16'h001F, 17};
    vecs[1] = '{0, 16'h007F, 16'h0000, 0,  16'h007F, 17};
    vecs[2] = '{0, 16'hA5C3, 16'h5A3C, 9,  16'hA5C3, 17};
    vecs[3] = '{0, 16'hFFFF, 16'h0000, 0,  16'hFFFF, 17};
    vecs[4] = '{1, 16'h03FF, 16'h0000, 20, 16'hFFC0, 65};
    vecs[5] = '{1, 16'h8001, 16'hFFFF, 0,  16'h8001, 65};
    vecs[6] = '{1, 16'h0F00, 16'h0000, 40, 16'h00F0, 65};
    vecs[7] = '{1, 16'h0001, 16'h0000, 0,  16'h8000, 65};

    drive(0, 1'b0, '0);
    drive(1, 1'b0, '0);
    rst = 1'b1;

    // Power-up: reset high for two edges, then idle with start low.
    step();
    chk("reset_outs_a", int'(outs(0)), 0);
    chk("reset_outs_b", int'(outs(1)), 0);
    step();
    rst = 1'b0;
    for (int i = 0; i < 4; i++) step();
    chk("idle_outs_a", int'(outs(0)), 0);
    chk("idle_outs_b", int'(outs(1)), 0);

    // Frame vectors.
    for (int k = 0; k < 8; k++) begin
      run_frame(vecs[k].sel, vecs[k].val, vecs[k].chg, vecs[k].poke,
                stream, busy_n, strobe_n, frame_n, done_at, tmo);
      chk($sformatf("v%0d_timeout", k), int'(tmo), 0);
      chk($sformatf("v%0d_stream", k), int'(stream), int'(vecs[k].exp_stream));
      chk($sformatf("v%0d_busy_len", k), busy_n, vecs[k].exp_busy);
      chk($sformatf("v%0d_strobes", k), strobe_n, 16);
      chk($sformatf("v%0d_frame_len", k), frame_n, vecs[k].exp_busy - 1);
      chk($sformatf("v%0d_done_at", k), done_at, vecs[k].exp_busy);
      step();
    end

    // Reset in the middle of a frame (bit 7 on the wire).
    drive(0, 1'b1, 16'hBEEF);
    for (int c = 1; c <= 8; c++) begin
      step();
      if (c == 1) drive(0, 1'b0, 16'h0000);
    end
    rst = 1'b1;
    step();
    chk("midreset_outs", int'(outs(0)), 0);
    rst = 1'b0;
    done_seen = 0;
    for (int c = 0; c < 20; c++) begin
      step();
      o = outs(0);
      if (o[0] || o[4]) done_seen++;
    end
    chk("midreset_no_done", done_seen, 0);
    run_frame(0, 16'h1234, 16'hFFFF, 0, stream, busy_n, strobe_n, frame_n, done_at, tmo);
    chk("after_reset_stream", int'(stream), 16'h1234);
    chk("after_reset_busy", busy_n, 17);

    // start held high: three back-to-back frames, one idle cycle between.
    prev_frame = 1'b0;
    drive(0, 1'b1, 16'h00FF);
    for (int c = 1; c <= 54; c++) begin
      step();
      o = outs(0);
      if (o[3] && !prev_frame) rises.push_back(c);
      if (o[0]) dones.push_back(c);
      prev_frame = o[3];
      drive(0, (c < 53), 16'($urandom));
    end
    chk("held_rises", rises.size(), 3);
    chk("held_dones", dones.size(), 3);
    for (int i = 0; i < 3; i++) begin
      if (i < rises.size()) chk($sformatf("held_rise%0d", i), rises[i], 1 + 18 * i);
      if (i < dones.size()) chk($sformatf("held_done%0d", i), dones[i], 17 + 18 * i);
    end

    // Randomized traffic on both instances, rare resets.
    for (int c = 0; c < 1500; c++) begin
      drive(0, ($urandom_range(0, 7) == 0), 16'($urandom));
      drive(1, ($urandom_range(0, 11) == 0), 16'($urandom));
      rst = ($urandom_range(0, 249) == 0);
      step();
    end
    rst = 1'b0;
    drive(0, 1'b0, '0);
    drive(1, 1'b0, '0);
    for (int c = 0; c < 70; c++) step();
    chk("drain_idle_a", int'(outs(0)), 0);
    chk("drain_idle_b", int'(outs(1)), 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
